// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and helpers for the PUF Hamming-distance engine
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } ham_state_t;

    localparam int PUF_WIDTH = 128;

    function automatic int dist_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// rtl/popcount_chunk.sv - combinational population count of one CHUNK-bit slice
module popcount_chunk #(
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [CW-1:0]    o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/hamming_engine.sv
// rtl/hamming_engine.sv - serial Hamming distance of response pairs with batch statistics
module hamming_engine
    import puf_pkg::*;
#(
    parameter int WIDTH = PUF_WIDTH,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16,
    parameter int DW    = dist_width(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    resp_a,
    input  logic [WIDTH-1:0]    resp_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       distance,
    input  logic                clear_stats,
    output logic [CNT_W-1:0]    pair_count,
    output logic [DW+CNT_W-1:0] dist_sum,
    output logic [DW-1:0]       dist_min,
    output logic [DW-1:0]       dist_max
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(CHUNK + 1);

    ham_state_t r_state, w_next;

    logic [WIDTH-1:0]    r_shift;
    logic [DW-1:0]       r_acc;
    logic [IW-1:0]       r_idx;
    logic [DW-1:0]       r_dist;
    logic [CNT_W-1:0]    r_pair_count;
    logic [DW+CNT_W-1:0] r_dist_sum;
    logic [DW-1:0]       r_dist_min;
    logic [DW-1:0]       r_dist_max;

    logic [CW-1:0] w_cnt;
    logic [DW-1:0] w_acc_next;
    logic          w_last;
    logic          w_out_hs;

    popcount_chunk #(.CHUNK(CHUNK), .CW(CW)) u_popcount (
        .i_bits  (r_shift[CHUNK-1:0]),
        .o_count (w_cnt)
    );

    assign w_acc_next = r_acc + DW'(w_cnt);
    assign w_last     = (r_idx == IW'(NCH - 1));
    assign w_out_hs   = (r_state == DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = COUNT;
            end
            COUNT: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_dist  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= resp_a ^ resp_b;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                COUNT: begin
                    r_shift <= r_shift >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) r_dist <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    // A clear on the handshake edge wins, so that pair never reaches the statistics.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_stats) begin
            r_pair_count <= '0;
            r_dist_sum   <= '0;
            r_dist_min   <= DW'(WIDTH);
            r_dist_max   <= '0;
        end else if (w_out_hs && (r_pair_count != '1)) begin
            r_pair_count <= r_pair_count + 1'b1;
            r_dist_sum   <= r_dist_sum + (DW+CNT_W)'(r_dist);
            if (r_dist < r_dist_min) r_dist_min <= r_dist;
            if (r_dist > r_dist_max) r_dist_max <= r_dist;
        end
    end

    assign distance   = r_dist;
    assign pair_count = r_pair_count;
    assign dist_sum   = r_dist_sum;
    assign dist_min   = r_dist_min;
    assign dist_max   = r_dist_max;

endmodule

// File: tb/tb_hamming_engine.sv
// tb/tb_hamming_engine.sv - directed self-checking bench for hamming_engine
module tb_hamming_engine;

    localparam int WIDTH = 128;
    localparam int CNT_W = 16;
    localparam int DW    = 8;
    localparam int LAT   = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    resp_a;
    logic [WIDTH-1:0]    resp_b;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       distance;
    logic                clear_stats;
    logic [CNT_W-1:0]    pair_count;
    logic [DW+CNT_W-1:0] dist_sum;
    logic [DW-1:0]       dist_min;
    logic [DW-1:0]       dist_max;

    int checks = 0;
    int errors = 0;

    hamming_engine #(.WIDTH(WIDTH), .CHUNK(8), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .resp_a      (resp_a),
        .resp_b      (resp_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .distance    (distance),
        .clear_stats (clear_stats),
        .pair_count  (pair_count),
        .dist_sum    (dist_sum),
        .dist_min    (dist_min),
        .dist_max    (dist_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               exp_dist;
        string            name;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Present a pair while in IDLE, then count cycles until out_valid.
    task automatic accept_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   output int lat);
        resp_a   = a;
        resp_b   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen_valid;

        vecs[0] = '{{4{32'hDEADBEEF}}, {4{32'hDEADBEEF}}, 0,   "equal"};
        vecs[1] = '{128'h0,            {128{1'b1}},       128, "all_ones"};
        vecs[2] = '{128'h0,            {16{8'hF0}},       64,  "nibbles"};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        resp_a      = '0;
        resp_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready",   in_ready,   1);
        check("rst_out_valid",  out_valid,  0);
        check("rst_distance",   distance,   0);
        check("rst_pair_count", pair_count, 0);
        check("rst_dist_sum",   dist_sum,   0);
        check("rst_dist_min",   dist_min,   128);
        check("rst_dist_max",   dist_max,   0);

        for (int i = 0; i < 3; i++) begin
            accept_and_wait(vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_latency"}, lat, LAT);
            check({vecs[i].name, "_distance"}, distance, vecs[i].exp_dist);
            handshake();
            check({vecs[i].name, "_valid_drop"}, out_valid, 0);
        end

        check("batch_pair_count", pair_count, 3);
        check("batch_dist_sum",   dist_sum,   192);
        check("batch_dist_min",   dist_min,   0);
        check("batch_dist_max",   dist_max,   128);

        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        check("clr_pair_count", pair_count, 0);
        check("clr_dist_sum",   dist_sum,   0);
        check("clr_dist_min",   dist_min,   128);
        check("clr_dist_max",   dist_max,   0);
        check("clr_keeps_distance", distance, 64);

        // Backpressure in DONE with a competing request that must be ignored.
        accept_and_wait(128'h0, 128'h1, lat);
        check("single_latency", lat, LAT);
        check("single_distance", distance, 1);
        resp_a   = '0;
        resp_b   = {128{1'b1}};
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_distance",  distance,  1);
            check("hold_in_ready",  in_ready,  0);
        end
        in_valid = 1'b0;
        handshake();
        check("release_out_valid", out_valid, 0);
        check("release_in_ready",  in_ready,  1);
        check("release_pair_count", pair_count, 1);
        check("release_dist_sum",   dist_sum,   1);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_req_idle", in_ready, 1);

        // Clear coinciding with the output handshake.
        accept_and_wait(128'h0, 128'h3_FFFF_FFFF_FFFF, lat);
        check("d50_distance", distance, 50);
        check("d50_out_valid", out_valid, 1);
        clear_stats = 1'b1;
        handshake();
        clear_stats = 1'b0;
        check("clrhs_pair_count", pair_count, 0);
        check("clrhs_dist_sum",   dist_sum,   0);
        check("clrhs_dist_min",   dist_min,   128);
        check("clrhs_dist_max",   dist_max,   0);
        check("clrhs_out_valid",  out_valid,  0);

        // Reset in the middle of counting discards the pair.
        resp_a   = '0;
        resp_b   = {128{1'b1}};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_distance",  distance,  0);
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", seen_valid, 0);

        accept_and_wait(128'h0, 128'h3, lat);
        check("post_rst_latency",  lat,      LAT);
        check("post_rst_distance", distance, 2);
        handshake();
        check("post_rst_pair_count", pair_count, 1);
        check("post_rst_dist_min",   dist_min,   2);
        check("post_rst_dist_max",   dist_max,   2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
